// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    // Width of requester IDs; also the low nibble of the header byte.
    localparam int ID_W = 4;

    // Default upper nibble of the frame header byte.
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    // Frame-level states: waiting, header, payload, checksum.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requester at or after
// last_grant+1 (wrapping) whose request bit is set.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [2*N_REQ-1:0] rot;
    int                 pos;

    // Rotate the doubled request vector so bit 0 is the highest-priority
    // requester, then take the lowest set bit and map it back to an ID.
    always_comb begin
        // NOTE: every variable gets a default first so no latch can be inferred.
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        rot   = {req, req} >> (last_grant + ID_W'(1));
        // Descending scan: the lowest offset with a request is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pos   = int'(last_grant) + 1 + k;
            end
        end
        if (pos >= N_REQ) begin
            pos = pos - N_REQ;
        end
        if (found) begin
            idx = ID_W'(pos);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of the UART transmitter.
// Each grant emits one frame: header {HDR_TAG, id}, payload bytes, XOR checksum.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         N_REQ   = 4,
    parameter int         DBIT    = 8,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      s_valid,
    input  logic [N_REQ*DBIT-1:0] s_data,
    input  logic [N_REQ-1:0]      s_last,
    output logic [N_REQ-1:0]      s_ready,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [DBIT-1:0]       w_data,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
);

    arb_state_t      state;
    logic [DBIT-1:0] csum;
    logic [ID_W-1:0] last_grant;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            cur_valid;
    logic            cur_last;
    logic [DBIT-1:0] cur_data;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req        (s_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // Multiplex the granted requester's byte stream.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                cur_valid = s_valid[i];
                cur_last  = s_last[i];
                cur_data  = s_data[i*DBIT +: DBIT];
            end
        end
    end

    // Combinational write strobe, data and acknowledge, so no write is ever
    // issued while tx_full is high, even against a one-entry FIFO.
    always_comb begin
        wr_uart = 1'b0;
        w_data  = '0;
        s_ready = '0;
        unique case (state)
            IDLE: ;
            HDR: begin
                w_data  = DBIT'({HDR_TAG, grant_id});
                wr_uart = ~tx_full;
            end
            DATA: begin
                w_data  = cur_data;
                wr_uart = cur_valid & ~tx_full;
                for (int i = 0; i < N_REQ; i++) begin
                    s_ready[i] = wr_uart && (grant_id == ID_W'(i));
                end
            end
            CSUM: begin
                w_data  = csum;
                wr_uart = ~tx_full;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    // Frame sequencer: arbitrate in IDLE, advance only on accepted writes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state      <= IDLE;
            csum       <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (wr_uart) begin
                        csum  <= w_data;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (wr_uart) begin
                        csum <= csum ^ w_data;
                        if (cur_last) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (wr_uart) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle-exact vector table, hand
// sequences for arbitration order and reset, and randomized traffic checked
// against a frame-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] s_valid;
    logic [N*8-1:0] s_data;
    logic [N-1:0] s_last;
    logic [N-1:0] s_ready;
    logic         tx_full;
    logic         wr_uart;
    logic [7:0]   w_data;
    logic         busy;
    logic [3:0]   grant_id;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .DBIT    (8),
        .HDR_TAG (4'hA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .tx_full  (tx_full),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus and the outputs expected before the next edge.
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic        wr;
        logic [7:0]  wd;
        logic [3:0]  rdy;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                       input logic f, input logic wr, input logic [7:0] wd,
                       input logic [3:0] rdy, input logic bsy);
        vec_t t;
        t.valid = v; t.data = d; t.last = l; t.full = f;
        t.wr = wr; t.wd = wd; t.rdy = rdy; t.bsy = bsy;
        vecs.push_back(t);
    endtask

    // Requester message queues ({last, byte}), model state and captured output.
    logic [8:0] msgq [N][$];
    bit         in_msg [N];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         mlast;

    task automatic apply_reset();
        rst = 1'b0;
        s_valid = '0; s_data = '0; s_last = '0; tx_full = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mlast = N - 1;
        for (int i = 0; i < N; i++) begin
            msgq[i].delete();
            in_msg[i] = 1'b0;
        end
    endtask

    task automatic load_msg(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            logic [7:0] byte_v;
            byte_v = 8'($urandom);
            msgq[r].push_back({(b == len - 1), byte_v});
        end
    endtask

    // Frame-level model: all loaded messages are pending at once, so frames
    // go out in pure round-robin order of requesters with work remaining.
    task automatic build_expected();
        logic [8:0] cp [N][$];
        exp_q.delete();
        for (int i = 0; i < N; i++) cp[i] = msgq[i];
        forever begin
            int   r;
            bit   any;
            logic [7:0] x;
            logic [8:0] b;
            any = 1'b0;
            r = 0;
            for (int k = 1; k <= N && !any; k++) begin
                if (cp[(mlast + k) % N].size() > 0) begin
                    r = (mlast + k) % N;
                    any = 1'b1;
                end
            end
            if (!any) break;
            x = {4'hA, 4'(r)};
            exp_q.push_back(x);
            do begin
                b = cp[r].pop_front();
                exp_q.push_back(b[7:0]);
                x = x ^ b[7:0];
            end while (!b[8]);
            exp_q.push_back(x);
            mlast = r;
        end
    endtask

    // Drive the queued messages into the DUT, optionally dropping s_valid
    // mid-message and asserting tx_full at random, and compare the stream.
    task automatic run(input int max_cyc, input bit drop_en, input int full_pct);
        bit done;
        bit acc [N];
        got.delete();
        done = 1'b0;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (msgq[i].size() > 0) begin
                    s_valid[i] = (drop_en && in_msg[i]) ? ($urandom_range(0, 3) != 0) : 1'b1;
                    s_data[i*8 +: 8] = msgq[i][0][7:0];
                    s_last[i] = msgq[i][0][8];
                end else begin
                    s_valid[i] = 1'b0;
                    s_data[i*8 +: 8] = 8'h00;
                    s_last[i] = 1'b0;
                end
            end
            tx_full = ($urandom_range(0, 99) < full_pct);
            @(negedge clk);
            if (wr_uart) begin
                check("write while tx_full", {31'd0, tx_full}, 32'd0);
                got.push_back(w_data);
            end
            done = !busy;
            for (int i = 0; i < N; i++) begin
                acc[i] = s_ready[i];
                if (s_ready[i]) check($sformatf("ready without valid r%0d", i), {31'd0, s_valid[i]}, 32'd1);
                if (msgq[i].size() > 0) done = 1'b0;
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    in_msg[i] = !msgq[i][0][8];
                    void'(msgq[i].pop_front());
                end
            end
        end
        s_valid = '0; tx_full = 1'b0;
        check("run completes", {31'd0, done}, 32'd1);
        check("frame byte count", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("frame byte %0d", i), got[i], exp_q[i]);
        end
    endtask

    initial begin
        rst = 1'b0;
        s_valid = '0; s_data = '0; s_last = '0; tx_full = 1'b0;
        mlast = N - 1;

        // Reset state.
        @(posedge clk); #1;
        @(negedge clk);
        check("reset wr_uart", {31'd0, wr_uart}, 32'd0);
        check("reset s_ready", {28'd0, s_ready}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset grant_id", {28'd0, grant_id}, 32'd0);
        check("reset w_data", {24'd0, w_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Requester 2, {0x11, 0x22 last}: checksum A2^11^22 = 91.
        add(4'b0100, 32'h0011_0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
        add(4'b0100, 32'h0011_0000, 4'b0000, 0, 1, 8'hA2, 4'b0000, 1);
        add(4'b0100, 32'h0011_0000, 4'b0000, 0, 1, 8'h11, 4'b0100, 1);
        add(4'b0100, 32'h0022_0000, 4'b0100, 0, 1, 8'h22, 4'b0100, 1);
        add(4'b0000, 32'h0000_0000, 4'b0000, 0, 1, 8'h91, 4'b0000, 1);
        add(4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
        // Requester 1 with tx_full stalls in HDR and 5 cycles in DATA; requester 3
        // raises valid mid-frame and must not be acknowledged. csum A1^5A^3C = C7.
        add(4'b0010, 32'h0000_5A00, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
        add(4'b0010, 32'h0000_5A00, 4'b0000, 1, 0, 8'hA1, 4'b0000, 1);
        add(4'b0010, 32'h0000_5A00, 4'b0000, 0, 1, 8'hA1, 4'b0000, 1);
        add(4'b0010, 32'h0000_5A00, 4'b0000, 1, 0, 8'h5A, 4'b0000, 1);
        for (int k = 0; k < 4; k++)
            add(4'b1010, 32'h7700_5A00, 4'b1000, 1, 0, 8'h5A, 4'b0000, 1);
        add(4'b1010, 32'h7700_5A00, 4'b1000, 0, 1, 8'h5A, 4'b0010, 1);
        add(4'b1010, 32'h7700_3C00, 4'b1010, 0, 1, 8'h3C, 4'b0010, 1);
        add(4'b1000, 32'h7700_0000, 4'b1000, 1, 0, 8'hC7, 4'b0000, 1);
        add(4'b1000, 32'h7700_0000, 4'b1000, 0, 1, 8'hC7, 4'b0000, 1);
        // Requester 3 is granted next: csum A3^77 = D4.
        add(4'b1000, 32'h7700_0000, 4'b1000, 0, 0, 8'h00, 4'b0000, 0);
        add(4'b1000, 32'h7700_0000, 4'b1000, 0, 1, 8'hA3, 4'b0000, 1);
        add(4'b1000, 32'h7700_0000, 4'b1000, 0, 1, 8'h77, 4'b1000, 1);
        add(4'b0000, 32'h0000_0000, 4'b0000, 0, 1, 8'hD4, 4'b0000, 1);
        add(4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
        // Requester 2 drops valid for 3 cycles mid-message: csum A2^10^20^33 = A1.
        add(4'b0100, 32'h0010_0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
        add(4'b0100, 32'h0010_0000, 4'b0000, 0, 1, 8'hA2, 4'b0000, 1);
        add(4'b0100, 32'h0010_0000, 4'b0000, 0, 1, 8'h10, 4'b0100, 1);
        add(4'b0100, 32'h0020_0000, 4'b0000, 0, 1, 8'h20, 4'b0100, 1);
        for (int k = 0; k < 3; k++)
            add(4'b0000, 32'h0033_0000, 4'b0100, 0, 0, 8'h33, 4'b0000, 1);
        add(4'b0100, 32'h0033_0000, 4'b0100, 0, 1, 8'h33, 4'b0100, 1);
        add(4'b0000, 32'h0000_0000, 4'b0000, 0, 1, 8'hA1, 4'b0000, 1);
        add(4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);

        foreach (vecs[k]) begin
            s_valid = vecs[k].valid;
            s_data  = vecs[k].data;
            s_last  = vecs[k].last;
            tx_full = vecs[k].full;
            @(negedge clk);
            check($sformatf("vec%0d wr_uart", k), {31'd0, wr_uart}, {31'd0, vecs[k].wr});
            check($sformatf("vec%0d w_data", k), {24'd0, w_data}, {24'd0, vecs[k].wd});
            check($sformatf("vec%0d s_ready", k), {28'd0, s_ready}, {28'd0, vecs[k].rdy});
            check($sformatf("vec%0d busy", k), {31'd0, busy}, {31'd0, vecs[k].bsy});
            @(posedge clk); #1;
        end

        // Round robin: 0, 1, 3 all pending with one-byte 0x00 messages.
        apply_reset();
        msgq[0].push_back(9'h100);
        msgq[1].push_back(9'h100);
        msgq[3].push_back(9'h100);
        build_expected();
        run(200, 1'b0, 0);
        if (got.size() >= 9) begin
            check("rr first header", got[0], 8'hA0);
            check("rr second header", got[3], 8'hA1);
            check("rr third header", got[6], 8'hA3);
        end else begin
            check("rr frame bytes", got.size(), 9);
        end
        // Re-raise 0 and 3: last grant was 3's predecessor chain ending at 3? No,
        // last grant is 3, so search starts at 0 -- but 3 was last, so wait:
        // the last frame went to 3, hence 0 comes first after wrap.
        msgq[0].push_back(9'h100);
        msgq[3].push_back(9'h100);
        build_expected();
        run(200, 1'b0, 0);
        if (got.size() >= 6) begin
            check("rr wrap first header", got[0], 8'hA0);
            check("rr wrap second header", got[3], 8'hA3);
        end else begin
            check("rr wrap frame bytes", got.size(), 6);
        end
        // After requester 1 is served, re-raising 0 and 3 must grant 3 first.
        apply_reset();
        msgq[1].push_back(9'h100);
        build_expected();
        run(200, 1'b0, 0);
        msgq[0].push_back(9'h100);
        msgq[3].push_back(9'h100);
        build_expected();
        run(200, 1'b0, 0);
        if (got.size() >= 6) begin
            check("rr after 1 first header", got[0], 8'hA3);
            check("rr after 1 second header", got[3], 8'hA0);
        end else begin
            check("rr after 1 frame bytes", got.size(), 6);
        end

        // Reset mid-frame after 0xA1 and 0x55 have been written.
        apply_reset();
        s_valid = 4'b0010; s_data = 32'h0000_5500; s_last = 4'b0000;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst seq header", {24'd0, w_data}, 32'hA1);
        check("rst seq header write", {31'd0, wr_uart}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst seq data", {24'd0, w_data}, 32'h55);
        check("rst seq data ready", {28'd0, s_ready}, 32'h2);
        @(posedge clk); #1;
        s_data = 32'h0000_6600;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        s_valid = 4'b0011; s_data = 32'h0000_660E; s_last = 4'b0011;
        @(negedge clk);
        check("post-reset wr_uart", {31'd0, wr_uart}, 32'd0);
        check("post-reset s_ready", {28'd0, s_ready}, 32'd0);
        check("post-reset busy", {31'd0, busy}, 32'd0);
        check("post-reset grant_id", {28'd0, grant_id}, 32'd0);
        check("post-reset w_data", {24'd0, w_data}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post-reset grant", {28'd0, grant_id}, 32'd0);
        check("post-reset header", {24'd0, w_data}, 32'hA0);
        @(posedge clk); #1;

        // Randomized traffic with valid drops and backpressure.
        apply_reset();
        for (int round = 0; round < 8; round++) begin
            for (int i = 0; i < N; i++) begin
                int nmsg;
                nmsg = $urandom_range(0, 2);
                for (int m = 0; m < nmsg; m++) load_msg(i, $urandom_range(1, 4));
            end
            build_expected();
            run(3000, 1'b1, 30);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
